// File: rtl/mbist_march_engine.sv
// mbist_march_engine
//   March C- memory BIST engine for one single-port SRAM macro.
//   Runs E0 w0 (up), E1 r0,w1 (up), E2 r1,w0 (up), E3 r0,w1 (down),
//   E4 r1,w0 (down), E5 r0 (up) over addresses 0..DEPTH-1 with full-word
//   compare, logging the first miscompare and counting all of them.
//
//   Optional feature macro: MBIST_CHECKERBOARD_EN
//     defined   -> a checkerboard background pass follows the solid pass
//     undefined -> solid background only, fail_bg tied to 0
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start, abort          begin test (IDLE/DONE only) / stop running test
//   mem_cs/we/re          memory strobes, mem_cs = mem_we | mem_re
//   mem_addr, mem_wdata   memory address and write data
//   mem_rdata             memory read data, valid READ_LATENCY cycles after mem_re
//   busy, test_done       op cycles in progress / sticky completion
//   fail_flag/addr/data/elem/bg   first-miscompare diagnostics
//   fail_count            saturating miscompare counter
module mbist_march_engine #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter int FAIL_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      mem_cs,
  output logic                      mem_we,
  output logic                      mem_re,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      busy,
  output logic                      test_done,
  output logic                      fail_flag,
  output logic [ADDR_WIDTH-1:0]     fail_addr,
  output logic [DATA_WIDTH-1:0]     fail_data,
  output logic [2:0]                fail_elem,
  output logic                      fail_bg,
  output logic [FAIL_CNT_WIDTH-1:0] fail_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_RWAIT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

`ifdef MBIST_CHECKERBOARD_EN
  localparam logic LAST_BG = 1'b1;
`else
  localparam logic LAST_BG = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0]     LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0]     ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]     ONE_ADDR  = ADDR_WIDTH'(1);
  localparam logic [2:0]                LAT_LAST  = 3'(READ_LATENCY - 1);
  localparam logic [FAIL_CNT_WIDTH-1:0] CNT_MAX   = {FAIL_CNT_WIDTH{1'b1}};

  // Background pattern P: all zeros for solid, bit i = i[0] ^ addr[0] for checkerboard.
  function automatic logic [DATA_WIDTH-1:0] bg_pattern(input logic bg, input logic a0);
    logic [DATA_WIDTH-1:0] p;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      p[i] = bg & (a0 ^ ((i % 2) == 1));
    end
    return p;
  endfunction

  state_t                state_r;
  logic [2:0]            elem_r;   // current March element 0..5
  logic                  op_r;     // op index within the element
  logic                  bg_r;     // 0 = solid, 1 = checkerboard
  logic [2:0]            lat_r;    // RWAIT cycle counter

  logic                  last_op_s;
  logic                  down_s;
  logic                  last_addr_s;
  logic [2:0]            nxt_elem_s;
  logic                  nxt_op_s;
  logic [ADDR_WIDTH-1:0] nxt_addr_s;
  logic                  nxt_bg_s;
  logic                  nxt_end_s;
  logic                  nxt_rd_s;
  logic                  nxt_inv_s;
  logic [DATA_WIDTH-1:0] nxt_data_s;
  logic                  adv_s;
  logic                  cmp_s;
  logic [DATA_WIDTH-1:0] syndrome_s;

  // E0 and E5 are single-op elements; E3/E4 sweep downward.
  assign last_op_s   = (elem_r == 3'd0) || (elem_r == 3'd5) || op_r;
  assign down_s      = (elem_r == 3'd3) || (elem_r == 3'd4);
  assign last_addr_s = down_s ? (mem_addr == ZERO_ADDR) : (mem_addr == LAST_ADDR);

  // Sequence to the op that follows the one currently presented.
  always_comb begin
    nxt_elem_s = elem_r;
    nxt_op_s   = 1'b0;
    nxt_addr_s = mem_addr;
    nxt_bg_s   = bg_r;
    nxt_end_s  = 1'b0;
    if (!last_op_s) begin
      nxt_op_s = 1'b1;
    end else if (!last_addr_s) begin
      if (down_s) begin
        nxt_addr_s = mem_addr - ONE_ADDR;
      end else begin
        nxt_addr_s = mem_addr + ONE_ADDR;
      end
    end else if (elem_r != 3'd5) begin
      nxt_elem_s = elem_r + 3'd1;
      // Elements 3 and 4 start at the top address.
      nxt_addr_s = ((elem_r == 3'd2) || (elem_r == 3'd3)) ? LAST_ADDR : ZERO_ADDR;
    end else if (bg_r != LAST_BG) begin
      nxt_bg_s   = 1'b1;
      nxt_elem_s = 3'd0;
      nxt_addr_s = ZERO_ADDR;
    end else begin
      nxt_end_s = 1'b1;
    end
    // First op of elements 1..5 is a read; the second op of 1..4 is a write.
    nxt_rd_s = (nxt_elem_s != 3'd0) && !nxt_op_s;
    if (nxt_op_s) begin
      nxt_inv_s = (nxt_elem_s == 3'd1) || (nxt_elem_s == 3'd3);
    end else begin
      nxt_inv_s = (nxt_elem_s == 3'd2) || (nxt_elem_s == 3'd4);
    end
    nxt_data_s = bg_pattern(nxt_bg_s, nxt_addr_s[0]) ^ {DATA_WIDTH{nxt_inv_s}};
  end

  // mem_wdata holds the expected word through the read latency window.
  assign cmp_s      = !abort && (state_r == ST_RWAIT) && (lat_r == LAT_LAST);
  assign adv_s      = cmp_s || (!abort && (state_r == ST_RUN) && !mem_re);
  assign syndrome_s = mem_rdata ^ mem_wdata;

  // Engine FSM, memory strobes and diagnostic status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      elem_r     <= 3'd0;
      op_r       <= 1'b0;
      bg_r       <= 1'b0;
      lat_r      <= 3'd0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= ZERO_ADDR;
      mem_wdata  <= {DATA_WIDTH{1'b0}};
      busy       <= 1'b0;
      test_done  <= 1'b0;
      fail_flag  <= 1'b0;
      fail_addr  <= ZERO_ADDR;
      fail_data  <= {DATA_WIDTH{1'b0}};
      fail_elem  <= 3'd0;
      fail_bg    <= 1'b0;
      fail_count <= {FAIL_CNT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            state_r    <= ST_RUN;
            elem_r     <= 3'd0;
            op_r       <= 1'b0;
            bg_r       <= 1'b0;
            lat_r      <= 3'd0;
            mem_cs     <= 1'b1;
            mem_we     <= 1'b1;
            mem_re     <= 1'b0;
            mem_addr   <= ZERO_ADDR;
            mem_wdata  <= {DATA_WIDTH{1'b0}};
            busy       <= 1'b1;
            test_done  <= 1'b0;
            fail_flag  <= 1'b0;
            fail_addr  <= ZERO_ADDR;
            fail_data  <= {DATA_WIDTH{1'b0}};
            fail_elem  <= 3'd0;
            fail_bg    <= 1'b0;
            fail_count <= {FAIL_CNT_WIDTH{1'b0}};
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN, ST_RWAIT: begin
          if (abort) begin
            state_r <= ST_IDLE;
            mem_cs  <= 1'b0;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
            busy    <= 1'b0;
          end else if ((state_r == ST_RUN) && mem_re) begin
            state_r <= ST_RWAIT;
            mem_cs  <= 1'b0;
            mem_re  <= 1'b0;
            lat_r   <= 3'd0;
          end else if ((state_r == ST_RWAIT) && (lat_r != LAT_LAST)) begin
            lat_r <= lat_r + 3'd1;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (cmp_s && (syndrome_s != {DATA_WIDTH{1'b0}})) begin
        if (fail_count != CNT_MAX) begin
          fail_count <= fail_count + FAIL_CNT_WIDTH'(1);
        end
        if (!fail_flag) begin
          fail_flag <= 1'b1;
          fail_addr <= mem_addr;
          fail_data <= syndrome_s;
          fail_elem <= elem_r;
`ifdef MBIST_CHECKERBOARD_EN
          fail_bg   <= bg_r;
`else
          fail_bg   <= 1'b0;
`endif
        end
      end

      if (adv_s) begin
        if (nxt_end_s) begin
          state_r   <= ST_DONE;
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          mem_re    <= 1'b0;
          busy      <= 1'b0;
          test_done <= 1'b1;
        end else begin
          state_r   <= ST_RUN;
          elem_r    <= nxt_elem_s;
          op_r      <= nxt_op_s;
          bg_r      <= nxt_bg_s;
          mem_cs    <= 1'b1;
          mem_we    <= !nxt_rd_s;
          mem_re    <= nxt_rd_s;
          mem_addr  <= nxt_addr_s;
          mem_wdata <= nxt_data_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_engine.sv
module tb_mbist_march_engine;

  localparam int AW  = 4;
  localparam int DEP = 10;
  localparam int DW  = 32;
  localparam int RL  = 3;
  localparam int FCW = 3;
`ifdef MBIST_CHECKERBOARD_EN
  localparam int NBG = 2;
`else
  localparam int NBG = 1;
`endif
  // 10 * (10 + 5*3) cycles per background
  localparam int K   = NBG * 250;
  // 5 writes and 5 reads per address per background
  localparam int NWR = NBG * 50;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            abort;
  logic            mem_cs, mem_we, mem_re;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy, test_done, fail_flag, fail_bg;
  logic [AW-1:0]   fail_addr;
  logic [DW-1:0]   fail_data;
  logic [2:0]      fail_elem;
  logic [FCW-1:0]  fail_count;

  mbist_march_engine #(
    .ADDR_WIDTH(AW), .DEPTH(DEP), .DATA_WIDTH(DW),
    .READ_LATENCY(RL), .FAIL_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .test_done(test_done), .fail_flag(fail_flag),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_elem(fail_elem),
    .fail_bg(fail_bg), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  longint cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model with stuck-at fault and read latency ----------
  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:RL-1];
  int            f_addr = -1;
  logic          f_all  = 1'b0;
  logic [DW-1:0] f_sa1  = '0;
  logic [DW-1:0] f_sa0  = '0;
  int            wr_cnt = 0, rd_cnt = 0, proto_err = 0;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] d, input int a);
    if (f_all || a == f_addr) return (d | f_sa1) & ~f_sa0;
    return d;
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rpipe[0] <= mem_re ? faulty(mem[mem_addr], int'(mem_addr)) : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    if (start && !busy) begin
      wr_cnt <= 0; rd_cnt <= 0; proto_err <= 0;
    end else begin
      if (mem_we) wr_cnt <= wr_cnt + 1;
      if (mem_re) rd_cnt <= rd_cnt + 1;
      if ((mem_cs != (mem_we | mem_re)) || (mem_cs && int'(mem_addr) >= DEP))
        proto_err <= proto_err + 1;
    end
  end
  assign mem_rdata = rpipe[RL-1];

  // ---------------- scoreboard ----------------
  typedef struct {
    longint        done_cyc;
    int            flag;
    int            cnt;
    int            addr;
    logic [DW-1:0] data;
    int            elem;
  } exp_t;
  exp_t sb[$];
  logic done_q = 1'b0;

  // Monitor: on each test_done rising edge, pop and compare the whole result.
  always @(negedge clk) begin
    exp_t e;
    done_q <= test_done;
    if (test_done && !done_q) begin
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("fail_flag", fail_flag, e.flag);
        chk("fail_count", fail_count, e.cnt);
        chk("fail_addr", fail_addr, e.addr);
        chk("fail_data", fail_data, e.data);
        chk("fail_elem", fail_elem, e.elem);
        chk("fail_bg", fail_bg, 0);
        chk("write_count", wr_cnt, NWR);
        chk("read_count", rd_cnt, NWR);
        chk("protocol_errors", proto_err, 0);
        chk("busy_after_done", busy, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_fault(input int a, input logic all, input logic [DW-1:0] s1,
                           input logic [DW-1:0] s0);
    f_addr = a; f_all = all; f_sa1 = s1; f_sa0 = s0;
  endtask

  // Returns T, the cycle in which start was sampled; leaves time at T+1 (+1).
  task automatic do_start(output longint t);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = cyc - 1;
    chk("first_op", {busy, mem_cs, mem_we, mem_re, mem_addr}, 8'b1110_0000);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!test_done && n < K + 20) begin
      @(posedge clk); #1; n++;
    end
    chk("done_within_budget", test_done, 1);
    @(negedge clk); #1;
  endtask

  task automatic run(input int flag, input int cnt, input int addr,
                     input logic [DW-1:0] data, input int elem, input bit poke_start);
    longint t;
    exp_t e;
    do_start(t);
    e.done_cyc = t + K + 1; e.flag = flag; e.cnt = cnt;
    e.addr = addr; e.data = data; e.elem = elem;
    sb.push_back(e);
    if (poke_start) begin
      repeat (20) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    longint t;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero", |{mem_cs, mem_we, mem_re, mem_addr, mem_wdata, busy,
        test_done, fail_flag, fail_addr, fail_data, fail_elem, fail_bg, fail_count}, 0);
    reset_n = 1'b1;

    // Fault-free, with a start pulse mid-run that must be ignored.
    set_fault(-1, 1'b0, '0, '0);
    run(0, 0, 0, 32'h0, 0, 1'b1);

    // Bit 3 stuck-at-1 at address 5: fails on every r0 -> E1, E3, E5 per background.
    set_fault(5, 1'b0, 32'h0000_0008, '0);
    run(1, 3 * NBG, 5, 32'h0000_0008, 1, 1'b0);

    // abort while done is ignored; status retained.
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_idle_done_kept", test_done, 1);
    chk("abort_idle_count_kept", fail_count, 3 * NBG);

    // Bit 31 stuck-at-0 at top address: first seen by the E2 r1, then E4.
    set_fault(9, 1'b0, '0, 32'h8000_0000);
    run(1, 2 * NBG, 9, 32'h8000_0000, 2, 1'b0);

    // Bit 0 stuck-at-1 everywhere: counter saturates at all-ones.
    set_fault(-1, 1'b1, 32'h0000_0001, '0);
    run(1, 7, 0, 32'h0000_0001, 1, 1'b0);

    // Abort at T+50 with the address-5 fault already logged (seen from T+40).
    set_fault(5, 1'b0, 32'h0000_0008, '0);
    do_start(t);
    repeat (49) @(posedge clk);
    #1;
    chk("busy_before_abort", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_strobes_busy_done", {mem_cs, mem_we, mem_re, busy, test_done}, 0);
    chk("abort_fail_flag_kept", fail_flag, 1);
    chk("abort_fail_count_kept", fail_count, 1);
    chk("abort_fail_addr_kept", fail_addr, 5);
    repeat (5) @(posedge clk);
    #1 chk("abort_stays_idle", {mem_cs, busy, test_done}, 0);
    set_fault(-1, 1'b0, '0, '0);
    run(0, 0, 0, 32'h0, 0, 1'b0);

    // Asynchronous reset mid-run.
    set_fault(5, 1'b0, 32'h0000_0008, '0);
    do_start(t);
    repeat (45) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs_zero", |{mem_cs, mem_we, mem_re, mem_addr, mem_wdata, busy,
        test_done, fail_flag, fail_addr, fail_data, fail_elem, fail_bg, fail_count}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("reset_stays_idle", {mem_cs, busy, test_done}, 0);
    set_fault(-1, 1'b0, '0, '0);
    run(0, 0, 0, 32'h0, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
